// File: rtl/program_memory_writer.sv
// Program memory writer: a byte-oriented host command interpreter that loads
// an address register and a data latch, writes or reads back program memory
// one word at a time, and controls the hold line of the core it programs.
module program_memory_writer #(
  parameter int ADDR_W = 12,  // program memory address width
  parameter int DATA_W = 14   // instruction word width
) (
  input  logic              clk,
  input  logic              reset,       // asynchronous, active-low
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_word,
  output logic              rd_valid,
  output logic              core_hold,
  output logic              cmd_err
);

  // Host command opcodes.
  localparam logic [7:0] OP_SET_ADDR  = 8'h01;
  localparam logic [7:0] OP_LOAD_DATA = 8'h02;
  localparam logic [7:0] OP_PROGRAM   = 8'h03;
  localparam logic [7:0] OP_READ      = 8'h04;
  localparam logic [7:0] OP_RUN       = 8'h05;

  // Only the low bits of the high argument byte ever reach the address or
  // data registers, so only those are stored.
  localparam int HI_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) - 8;

  typedef enum logic [2:0] {
    IDLE,      // waiting for a command byte
    ARG_HI,    // waiting for the high argument byte
    ARG_LO,    // waiting for the low argument byte
    WRITE,     // write strobe cycle
    RD_ISSUE,  // read request cycle
    RD_CAP     // memory data valid, captured at the end of this cycle
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic [HI_W-1:0]     hi_q,        hi_d;
  logic                op_data_q,   op_data_d;   // 1: LOAD_DATA, 0: SET_ADDR
  logic [DATA_W-1:0]   rd_word_q,   rd_word_d;
  logic                rd_valid_q,  rd_valid_d;
  logic                core_hold_q, core_hold_d;
  logic                cmd_err_q,   cmd_err_d;

  logic                accept;

  // A byte transfers only when the host offers it and the FSM can take it.
  assign byte_ready = (state_q == IDLE) || (state_q == ARG_HI) || (state_q == ARG_LO);
  assign accept     = byte_valid && byte_ready;

  // Memory strobes decode straight from the state register, so they are
  // exclusive by construction and vanish the instant reset forces IDLE.
  assign mem_we    = (state_q == WRITE);
  assign mem_re    = (state_q == RD_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign rd_word   = rd_word_q;
  assign rd_valid  = rd_valid_q;
  assign core_hold = core_hold_q;
  assign cmd_err   = cmd_err_q;

  // Next-state and register-update logic for the command interpreter.
  always_comb begin
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    hi_d        = hi_q;
    op_data_d   = op_data_q;
    rd_word_d   = rd_word_q;
    rd_valid_d  = 1'b0;
    core_hold_d = core_hold_q;
    cmd_err_d   = cmd_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (byte_in)
            OP_SET_ADDR: begin
              op_data_d   = 1'b0;
              core_hold_d = 1'b1;
              state_d     = ARG_HI;
            end
            OP_LOAD_DATA: begin
              op_data_d   = 1'b1;
              core_hold_d = 1'b1;
              state_d     = ARG_HI;
            end
            OP_PROGRAM: begin
              core_hold_d = 1'b1;
              state_d     = WRITE;
            end
            OP_READ: begin
              core_hold_d = 1'b1;
              state_d     = RD_ISSUE;
            end
            OP_RUN: begin
              // Releases the core; the interpreter keeps listening.
              core_hold_d = 1'b0;
            end
            default: begin
              // Unknown byte is swallowed and flagged; nothing else moves.
              cmd_err_d = 1'b1;
            end
          endcase
        end
      end

      ARG_HI: begin
        if (accept) begin
          hi_d    = byte_in[HI_W-1:0];
          state_d = ARG_LO;
        end
      end

      ARG_LO: begin
        if (accept) begin
          if (op_data_q) begin
            data_d = {hi_q[DATA_W-9:0], byte_in};
          end else begin
            addr_d = {hi_q[ADDR_W-9:0], byte_in};
          end
          state_d = IDLE;
        end
      end

      WRITE: begin
        // Strobe is high for this single cycle; step to the next word after it.
        addr_d  = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end

      RD_ISSUE: begin
        state_d = RD_CAP;
      end

      RD_CAP: begin
        // Registered memory presents the word during this cycle.
        rd_word_d  = mem_rdata;
        rd_valid_d = 1'b1;
        addr_d     = addr_q + ADDR_W'(1);
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      hi_q        <= '0;
      op_data_q   <= 1'b0;
      rd_word_q   <= '0;
      rd_valid_q  <= 1'b0;
      core_hold_q <= 1'b1;
      cmd_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      hi_q        <= hi_d;
      op_data_q   <= op_data_d;
      rd_word_q   <= rd_word_d;
      rd_valid_q  <= rd_valid_d;
      core_hold_q <= core_hold_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_program_memory_writer.sv
// Directed bench for program_memory_writer: a behavioural registered-read
// memory, a scoreboard of expected writes and read-backs, and a linear
// sequence of host byte streams.
module tb_program_memory_writer;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 14;

  logic              clk;
  logic              reset;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_word;
  logic              rd_valid;
  logic              core_hold;
  logic              cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] rd_q[$];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  program_memory_writer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .rd_word    (rd_word),
    .rd_valid   (rd_valid),
    .core_hold  (core_hold),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory model with a registered read port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe or read-back must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_we || mem_re) check("we_re_exclusive", {31'd0, mem_we && mem_re}, 32'd0);
    if (mem_we) begin
      check("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (rd_valid) begin
      check("read_expected", {31'd0, rd_q.size() != 0}, 32'd1);
      if (rd_q.size() != 0) begin
        logic [DATA_W-1:0] r;
        r = rd_q.pop_front();
        check("read_word", 32'(rd_word), 32'(r));
      end
    end
  end

  // Offer one byte and return 1 time unit after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_mem_we",    32'(mem_we),    32'h0);
    check("rst_mem_re",    32'(mem_re),    32'h0);
    check("rst_rd_valid",  32'(rd_valid),  32'h0);
    check("rst_rd_word",   32'(rd_word),   32'h0);
    check("rst_cmd_err",   32'(cmd_err),   32'h0);
    check("rst_core_hold", 32'(core_hold), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'h1);

    // RUN releases the core, PROGRAM re-asserts hold.
    send_byte(8'h05);
    check("run_core_hold", 32'(core_hold), 32'h0);
    check("run_ready", 32'(byte_ready), 32'h1);
    push_wr(12'h000, 14'h0000);
    send_byte(8'h03);
    check("prog_core_hold", 32'(core_hold), 32'h1);
    check("prog_we_cycle", 32'(mem_we), 32'h1);
    check("prog_not_ready", 32'(byte_ready), 32'h0);
    @(posedge clk); #1;
    check("prog_we_drop", 32'(mem_we), 32'h0);
    check("prog_addr_inc", 32'(mem_addr), 32'h001);

    // Set address, load data, program.
    send_byte(8'h05);
    send_byte(8'h01);
    check("setaddr_hold", 32'(core_hold), 32'h1);
    send_byte(8'h00);
    send_byte(8'h10);
    check("setaddr_010", 32'(mem_addr), 32'h010);
    send_byte(8'h02);
    send_byte(8'h2A);
    send_byte(8'hBC);
    check("load_2abc", 32'(mem_wdata), 32'h2ABC);
    check("load_keeps_addr", 32'(mem_addr), 32'h010);
    push_wr(12'h010, 14'h2ABC);
    send_byte(8'h03);
    check("prog2_we", 32'(mem_we), 32'h1);
    @(posedge clk); #1;
    check("prog2_addr_011", 32'(mem_addr), 32'h011);

    // Unused high argument bits are dropped.
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h34);
    check("hi_bits_addr", 32'(mem_addr), 32'hF34);
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h00);
    check("hi_bits_data", 32'(mem_wdata), 32'h3F00);

    // Write at the top address wraps to 0; a byte offered while busy waits.
    send_byte(8'h01); send_byte(8'h0F); send_byte(8'hFF);
    push_wr(12'hFFF, 14'h3F00);
    send_byte(8'h03);
    check("wrap_we", 32'(mem_we), 32'h1);
    check("wrap_we_addr", 32'(mem_addr), 32'hFFF);
    byte_in    = 8'h05;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    check("wrap_addr_000", 32'(mem_addr), 32'h000);
    check("busy_byte_ignored", 32'(core_hold), 32'h1);
    check("busy_then_ready", 32'(byte_ready), 32'h1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    check("held_byte_taken", 32'(core_hold), 32'h0);

    // Store 0x3FFF at 0x020 and read it back with exact timing.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h02); send_byte(8'h3F); send_byte(8'hFF);
    push_wr(12'h020, 14'h3FFF);
    send_byte(8'h03);
    @(posedge clk); #1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    rd_q.push_back(14'h3FFF);
    send_byte(8'h04);
    check("rd_re_cycle", 32'(mem_re), 32'h1);
    check("rd_no_we", 32'(mem_we), 32'h0);
    check("rd_busy1", 32'(byte_ready), 32'h0);
    check("rd_re_addr", 32'(mem_addr), 32'h020);
    @(posedge clk); #1;
    check("rd_re_drop", 32'(mem_re), 32'h0);
    check("rd_busy2", 32'(byte_ready), 32'h0);
    check("rd_valid_early", 32'(rd_valid), 32'h0);
    @(posedge clk); #1;
    check("rd_valid_pulse", 32'(rd_valid), 32'h1);
    check("rd_word_3fff", 32'(rd_word), 32'h3FFF);
    check("rd_addr_021", 32'(mem_addr), 32'h021);
    check("rd_ready_back", 32'(byte_ready), 32'h1);
    @(posedge clk); #1;
    check("rd_valid_one_cycle", 32'(rd_valid), 32'h0);
    check("rd_word_held", 32'(rd_word), 32'h3FFF);

    // Read back an earlier write.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    rd_q.push_back(14'h2ABC);
    send_byte(8'h04);
    repeat (2) @(posedge clk); #1;
    check("rb_valid", 32'(rd_valid), 32'h1);
    check("rb_word", 32'(rd_word), 32'h2ABC);
    check("rb_addr", 32'(mem_addr), 32'h011);

    // Unknown opcode and command-valued argument bytes.
    send_byte(8'h05);
    send_byte(8'h7E);
    check("unk_cmd_err", 32'(cmd_err), 32'h1);
    check("unk_addr_kept", 32'(mem_addr), 32'h011);
    check("unk_data_kept", 32'(mem_wdata), 32'h3FFF);
    check("unk_hold_kept", 32'(core_hold), 32'h0);
    check("unk_ready", 32'(byte_ready), 32'h1);
    send_byte(8'h01);
    send_byte(8'h03);
    check("arg_no_we", 32'(mem_we), 32'h0);
    repeat (2) @(negedge clk);
    check("arg_still_ready", 32'(byte_ready), 32'h1);
    send_byte(8'h40);
    check("arg_lo_addr", 32'(mem_addr), 32'h340);
    check("cmd_err_sticky", 32'(cmd_err), 32'h1);

    // Reset during the write cycle.
    send_byte(8'h03);
    #1 reset = 1'b0;
    #1;
    check("rstw_we_drop", 32'(mem_we), 32'h0);
    check("rstw_addr", 32'(mem_addr), 32'h0);
    check("rstw_hold", 32'(core_hold), 32'h1);
    check("rstw_cmd_err", 32'(cmd_err), 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_no_strobe", 32'(mem_we), 32'h0);

    // Reset during a read request: no read-back follows.
    send_byte(8'h04);
    #1 reset = 1'b0;
    #1;
    check("rstr_re_drop", 32'(mem_re), 32'h0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rstr_no_valid", 32'(rd_valid), 32'h0);

    // Reset while waiting for the low argument byte: next byte is a command.
    send_byte(8'h01);
    send_byte(8'h05);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    push_wr(12'h000, 14'h0000);
    send_byte(8'h03);
    check("rsta_prog_we", 32'(mem_we), 32'h1);
    @(posedge clk); #1;
    check("rsta_addr", 32'(mem_addr), 32'h001);

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(wr_q.size()), 32'h0);
    check("reads_drained", 32'(rd_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
